// File: rtl/bsg_axil_txs.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | bsg_axil_txs : AXI-Lite write slave; TDR writes push tx FIFOs, other slot   |
// | offsets strobe config registers. Optional: BSG_AXIL_TXS_WSTRB_CHECK_EN.     |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module bsg_axil_txs #(
  parameter int unsigned                  num_fifos_p       = 2,
  parameter int unsigned                  base_addr_width_p = 8,
  parameter int unsigned                  slot_idx_width_p  = 4,
  parameter logic [31:0]                  slot_base_addr_p  = 32'h0000_1000,
  parameter logic [base_addr_width_p-1:0] tdr_ofs_p         = 8'h10
) (
  input  logic                        clk_i,
  input  logic                        reset_ni,

  input  logic [31:0]                 awaddr_i,
  input  logic                        awvalid_i,
  output logic                        awready_o,
  input  logic [31:0]                 wdata_i,
  input  logic [3:0]                  wstrb_i,
  input  logic                        wvalid_i,
  output logic                        wready_o,
  output logic [1:0]                  bresp_o,
  output logic                        bvalid_o,
  input  logic                        bready_i,

  output logic [num_fifos_p-1:0][31:0] txs_o,
  output logic [num_fifos_p-1:0]      txs_v_o,
  input  logic [num_fifos_p-1:0]      txs_ready_i,

  output logic [31:0]                 wr_addr_o,
  output logic [31:0]                 wr_data_o,
  output logic                        wr_v_o
);

  typedef enum logic [1:0] {
    E_WR_IDLE = 2'd0,
    E_WR_EXEC = 2'd1,
    E_WR_RESP = 2'd2
  } wr_state_e;

  localparam logic [1:0] c_RESP_OKAY   = 2'b00;
  localparam logic [1:0] c_RESP_SLVERR = 2'b10;
  localparam logic [1:0] c_RESP_DECERR = 2'b11;

  localparam int unsigned c_UP_LSB = base_addr_width_p + slot_idx_width_p;
  // Slot-index field value of slot 0, truncated to the width of the field.
  localparam logic [slot_idx_width_p-1:0] c_SLOT0_IDX =
    slot_idx_width_p'(slot_base_addr_p >> base_addr_width_p);

  wr_state_e   state_q;
  logic        aw_cap_q, w_cap_q;
  logic        awready_q, wready_q;
  logic [31:0] addr_q, data_q;
  logic [3:0]  strb_q;
  logic [1:0]  bresp_q;

  logic        w_aw_hs, w_w_hs;
  logic        aw_cap_d, w_cap_d;
  logic        w_exec;
  logic        w_upper_ok, w_ofs_is_tdr;
  logic [num_fifos_p-1:0] w_slot_hit, w_tdr_hit;
  logic        w_any_slot, w_any_tdr, w_tdr_ready;
  logic        w_strb_err;
  logic        w_wr_v;

  assign w_aw_hs  = awvalid_i & awready_q;
  assign w_w_hs   = wvalid_i & wready_q;
  assign aw_cap_d = aw_cap_q | w_aw_hs;
  assign w_cap_d  = w_cap_q | w_w_hs;
  assign w_exec   = (state_q == E_WR_EXEC);

  assign w_upper_ok   = (addr_q[31:c_UP_LSB] == slot_base_addr_p[31:c_UP_LSB]);
  assign w_ofs_is_tdr = (addr_q[base_addr_width_p-1:0] == tdr_ofs_p);

  for (genvar i = 0; i < num_fifos_p; i++) begin : g_slot
    assign w_slot_hit[i] = w_upper_ok &
      (addr_q[base_addr_width_p +: slot_idx_width_p] == c_SLOT0_IDX + slot_idx_width_p'(i));
    assign w_tdr_hit[i]  = w_slot_hit[i] & w_ofs_is_tdr;
    assign txs_o[i]      = data_q;
  end

  assign w_any_slot  = |w_slot_hit;
  assign w_any_tdr   = |w_tdr_hit;
  assign w_tdr_ready = |(w_tdr_hit & txs_ready_i);

`ifdef BSG_AXIL_TXS_WSTRB_CHECK_EN
  assign w_strb_err = (strb_q != 4'hF);
`else
  logic w_unused_strb;
  assign w_strb_err    = 1'b0;
  assign w_unused_strb = ^strb_q;
`endif

  assign txs_v_o   = w_tdr_hit & {num_fifos_p{w_exec & ~w_strb_err}};
  assign w_wr_v    = w_exec & w_any_slot & ~w_any_tdr;
  assign wr_v_o    = w_wr_v;
  assign wr_addr_o = w_wr_v ? addr_q : 32'h0;
  assign wr_data_o = w_wr_v ? data_q : 32'h0;

  assign awready_o = awready_q;
  assign wready_o  = wready_q;
  assign bvalid_o  = (state_q == E_WR_RESP);
  assign bresp_o   = bvalid_o ? bresp_q : 2'b00;

  // Ready flags are registered so they stay low while reset is held.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q   <= E_WR_IDLE;
      aw_cap_q  <= 1'b0;
      w_cap_q   <= 1'b0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      addr_q    <= 32'h0;
      data_q    <= 32'h0;
      strb_q    <= 4'h0;
      bresp_q   <= c_RESP_OKAY;
    end else begin
      case (state_q)
        E_WR_IDLE: begin
          if (w_aw_hs) addr_q <= awaddr_i;
          if (w_w_hs) begin
            data_q <= wdata_i;
            strb_q <= wstrb_i;
          end
          if (aw_cap_d && w_cap_d) begin
            state_q   <= E_WR_EXEC;
            aw_cap_q  <= 1'b0;
            w_cap_q   <= 1'b0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
          end else begin
            aw_cap_q  <= aw_cap_d;
            w_cap_q   <= w_cap_d;
            awready_q <= ~aw_cap_d;
            wready_q  <= ~w_cap_d;
          end
        end
        E_WR_EXEC: begin
          if (w_any_tdr && !w_strb_err) begin
            // A full FIFO stalls here until it drains; there is no timeout.
            if (w_tdr_ready) begin
              bresp_q <= c_RESP_OKAY;
              state_q <= E_WR_RESP;
            end
          end else if (w_any_tdr) begin
            bresp_q <= c_RESP_SLVERR;
            state_q <= E_WR_RESP;
          end else if (w_any_slot) begin
            bresp_q <= c_RESP_OKAY;
            state_q <= E_WR_RESP;
          end else begin
            bresp_q <= c_RESP_DECERR;
            state_q <= E_WR_RESP;
          end
        end
        E_WR_RESP: begin
          if (bready_i) begin
            state_q   <= E_WR_IDLE;
            awready_q <= 1'b1;
            wready_q  <= 1'b1;
          end
        end
        default: state_q <= E_WR_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
